pipe_idex_reg: RTL and testbench
================================

// Module: pipe_idex_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage pipeline: captures decoded control, register-file operands,
//  immediate, shift amount and PC+4 from ID, and presents the ALU operands (alua, alub, aluc) to EX.
//  Supports hold (downstream stall), bubble insertion (load-use hazard) and flush (taken branch/jump).
//  Keeps a saturating count of killed slots for performance monitoring.
// PARAMETERS
//  WIDTH   32  datapath width (operands, immediate, PC+4, counter)
//  RWIDTH  5   register-number and shift-amount width
// PORTS
//  clock     in   1       single clock, all state updates on rising edge
//  resetn    in   1       asynchronous, active-low reset
//  en        in   1       1 = register may update; 0 = hold all contents
//  bubble    in   1       load a NOP instead of the ID instruction (honoured only when en=1)
//  flush     in   1       kill the slot; overrides en and bubble
//  d_wreg    in   1       ID: writes register file
//  d_m2reg   in   1       ID: result comes from memory
//  d_wmem    in   1       ID: writes data memory
//  d_jal     in   1       ID: jump-and-link
//  d_aluimm  in   1       ID: ALU b operand is immediate
//  d_shift   in   1       ID: ALU a operand is shift amount
//  d_aluc    in   4       ID: ALU control code
//  d_rn      in   RWIDTH  ID: destination register number
//  d_sa      in   RWIDTH  ID: shift amount field
//  d_qa      in   WIDTH   ID: forwarded rs value
//  d_qb      in   WIDTH   ID: forwarded rt value
//  d_imm     in   WIDTH   ID: extended immediate
//  d_pc4     in   WIDTH   ID: PC+4
//  e_wreg, e_m2reg, e_wmem, e_jal  out 1  registered controls to EX/MEM
//  e_rn      out  RWIDTH  registered destination (31 when e_jal=1)
//  e_qb      out  WIDTH   registered rt value (store data)
//  e_alua    out  WIDTH   ALU a operand
//  e_alub    out  WIDTH   ALU b operand
//  e_aluc    out  4       ALU control code
//  kill_cnt  out  WIDTH   number of killed slots, saturating
// BEHAVIOUR
//  - Reset (resetn=0, async): every stored field and kill_cnt = 0; outputs therefore e_alua=0,
//    e_alub=0, e_aluc=4'b0000 (ADD), all controls 0, e_rn=0.
//  - Per edge, priority: flush > (en=0 hold) > bubble > normal load.
//    flush=1: all stored fields cleared (as reset); kill_cnt +1.
//    en=0, flush=0: all fields hold; kill_cnt holds.
//    en=1, bubble=1: wreg, m2reg, wmem, jal cleared; data fields (qa,qb,imm,sa,pc4,rn,aluc) loaded
//    from ID (don't-care, no side effects); kill_cnt +1.
//    en=1, bubble=0: all fields loaded from ID.
//  - Latency: one cycle ID->EX; operand outputs are combinational from stored fields only (no path
//    from d_* inputs to e_* outputs).
//  - Operand select: e_jal=1 -> e_alua=pc4, e_alub=4, e_aluc=4'b0000 (ADD), e_rn=31;
//    else e_alua = shift ? zero-extended sa : qa; e_alub = aluimm ? imm : qb; e_aluc=stored aluc.
//  - sa zero-extended from RWIDTH to WIDTH; no other width conversion.
//  - kill_cnt saturates at all-ones; never wraps. Stays at all-ones until reset.
//  - Reset asserted mid-operation overrides everything immediately; first edge after release is a
//    normal cycle.
// STRUCTURE
//  - Shared package: ALU code constants (ALU_ADD=4'b0000 etc.), link register number (31),
//    link offset (4), WIDTH/RWIDTH defaults.
//  - One natural sub-module: sat_counter (WIDTH, inc, clock, resetn) for kill_cnt; rest inline.
// TESTING
//  1 Reset: resetn=0 with random d_* -> all outputs 0, e_aluc=0000; release, load add -> values next cycle.
//  2 Normal load: qa=5, qb=7, aluimm=0, shift=0, aluc=0000, wreg=1, rn=3 -> e_alua=5, e_alub=7, e_wreg=1, e_rn=3.
//  3 Immediate/shift: shift=1, sa=4, qb=0x10, aluc=0011 -> e_alua=4, e_alub=0x10; aluimm=1, imm=0xFFFF -> e_alub=0xFFFF.
//  4 JAL: jal=1, pc4=0x100 -> e_alua=0x100, e_alub=4, e_aluc=0000, e_rn=31.
//  5 Hazards: bubble=1 with wreg=1,wmem=1 -> e_wreg=e_wmem=0, kill_cnt=1; en=0 -> outputs frozen;
//    flush=1 with en=0 -> cleared, kill_cnt=2.
//  6 Saturation: force kill_cnt=0xFFFFFFFE, two flushes -> 0xFFFFFFFF, stays.

Source files
------------

// File: rtl/pipe_idex_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths, ALU codes,
// link constants and the per-edge slot operation decode.
package pipe_idex_reg_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int RWIDTH_DEF = 5;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam int LINK_REG    = 31;
  localparam int LINK_OFFSET = 4;

  typedef enum logic [1:0] {
    SLOT_LOAD   = 2'b00,
    SLOT_BUBBLE = 2'b01,
    SLOT_HOLD   = 2'b10,
    SLOT_FLUSH  = 2'b11
  } slot_op_e;

  // Flush beats a stall, and a stall beats a bubble request.
  function automatic slot_op_e slotOp(input logic en, input logic bubble, input logic flush);
    slot_op_e op;
    if (flush)       op = SLOT_FLUSH;
    else if (!en)    op = SLOT_HOLD;
    else if (bubble) op = SLOT_BUBBLE;
    else             op = SLOT_LOAD;
    return op;
  endfunction

endpackage

// File: rtl/pipe_idex_reg_sat_counter.sv
// Saturating up-counter used to count killed pipeline slots; sticks at all-ones.
module pipe_idex_reg_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic             w_full;

  assign w_full = &r_count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_idex_reg.sv
// ID/EX pipeline register: stores decoded ID fields and presents ALU operands to EX,
// with stall hold, load-use bubble, branch flush and a killed-slot counter.
module pipe_idex_reg
  import pipe_idex_reg_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int RWIDTH = RWIDTH_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              en,
  input  logic              bubble,
  input  logic              flush,
  input  logic              d_wreg,
  input  logic              d_m2reg,
  input  logic              d_wmem,
  input  logic              d_jal,
  input  logic              d_aluimm,
  input  logic              d_shift,
  input  logic [3:0]        d_aluc,
  input  logic [RWIDTH-1:0] d_rn,
  input  logic [RWIDTH-1:0] d_sa,
  input  logic [WIDTH-1:0]  d_qa,
  input  logic [WIDTH-1:0]  d_qb,
  input  logic [WIDTH-1:0]  d_imm,
  input  logic [WIDTH-1:0]  d_pc4,
  output logic              e_wreg,
  output logic              e_m2reg,
  output logic              e_wmem,
  output logic              e_jal,
  output logic [RWIDTH-1:0] e_rn,
  output logic [WIDTH-1:0]  e_qb,
  output logic [WIDTH-1:0]  e_alua,
  output logic [WIDTH-1:0]  e_alub,
  output logic [3:0]        e_aluc,
  output logic [WIDTH-1:0]  kill_cnt
);

  logic              r_wreg;
  logic              r_m2reg;
  logic              r_wmem;
  logic              r_jal;
  logic              r_aluimm;
  logic              r_shift;
  logic [3:0]        r_aluc;
  logic [RWIDTH-1:0] r_rn;
  logic [RWIDTH-1:0] r_sa;
  logic [WIDTH-1:0]  r_qa;
  logic [WIDTH-1:0]  r_qb;
  logic [WIDTH-1:0]  r_imm;
  logic [WIDTH-1:0]  r_pc4;

  slot_op_e          w_op;
  logic              w_kill;
  logic [WIDTH-1:0]  w_saExt;

  assign w_op   = slotOp(en, bubble, flush);
  assign w_kill = (w_op == SLOT_FLUSH) || (w_op == SLOT_BUBBLE);

  // A bubble still loads the data fields; only the side-effecting controls are dropped.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wreg   <= 1'b0;
      r_m2reg  <= 1'b0;
      r_wmem   <= 1'b0;
      r_jal    <= 1'b0;
      r_aluimm <= 1'b0;
      r_shift  <= 1'b0;
      r_aluc   <= ALU_ADD;
      r_rn     <= '0;
      r_sa     <= '0;
      r_qa     <= '0;
      r_qb     <= '0;
      r_imm    <= '0;
      r_pc4    <= '0;
    end else begin
      case (w_op)
        SLOT_FLUSH: begin
          r_wreg   <= 1'b0;
          r_m2reg  <= 1'b0;
          r_wmem   <= 1'b0;
          r_jal    <= 1'b0;
          r_aluimm <= 1'b0;
          r_shift  <= 1'b0;
          r_aluc   <= ALU_ADD;
          r_rn     <= '0;
          r_sa     <= '0;
          r_qa     <= '0;
          r_qb     <= '0;
          r_imm    <= '0;
          r_pc4    <= '0;
        end
        SLOT_BUBBLE: begin
          r_wreg   <= 1'b0;
          r_m2reg  <= 1'b0;
          r_wmem   <= 1'b0;
          r_jal    <= 1'b0;
          r_aluimm <= d_aluimm;
          r_shift  <= d_shift;
          r_aluc   <= d_aluc;
          r_rn     <= d_rn;
          r_sa     <= d_sa;
          r_qa     <= d_qa;
          r_qb     <= d_qb;
          r_imm    <= d_imm;
          r_pc4    <= d_pc4;
        end
        SLOT_LOAD: begin
          r_wreg   <= d_wreg;
          r_m2reg  <= d_m2reg;
          r_wmem   <= d_wmem;
          r_jal    <= d_jal;
          r_aluimm <= d_aluimm;
          r_shift  <= d_shift;
          r_aluc   <= d_aluc;
          r_rn     <= d_rn;
          r_sa     <= d_sa;
          r_qa     <= d_qa;
          r_qb     <= d_qb;
          r_imm    <= d_imm;
          r_pc4    <= d_pc4;
        end
        default: begin
        end
      endcase
    end
  end

  assign w_saExt = {{(WIDTH-RWIDTH){1'b0}}, r_sa};

  // Operands come only from stored fields; jal turns the ALU into a PC+4 adder.
  always_comb begin
    e_alua = r_shift  ? w_saExt : r_qa;
    e_alub = r_aluimm ? r_imm   : r_qb;
    e_aluc = r_aluc;
    e_rn   = r_rn;
    if (r_jal) begin
      e_alua = r_pc4;
      e_alub = WIDTH'(LINK_OFFSET);
      e_aluc = ALU_ADD;
      e_rn   = RWIDTH'(LINK_REG);
    end
  end

  assign e_wreg  = r_wreg;
  assign e_m2reg = r_m2reg;
  assign e_wmem  = r_wmem;
  assign e_jal   = r_jal;
  assign e_qb    = r_qb;

  pipe_idex_reg_sat_counter #(
    .WIDTH (WIDTH)
  ) u_killCnt (
    .clock  (clock),
    .resetn (resetn),
    .inc    (w_kill),
    .count  (kill_cnt)
  );

endmodule

// File: tb/tb_pipe_idex_reg.sv
// Bench for pipe_idex_reg: directed vector table plus reset, async-reset and
// kill-counter saturation sequences (saturation on a narrow second instance).
module tb_pipe_idex_reg;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        en, bubble, flush;
  logic        d_wreg, d_m2reg, d_wmem, d_jal, d_aluimm, d_shift;
  logic [3:0]  d_aluc;
  logic [4:0]  d_rn, d_sa;
  logic [31:0] d_qa, d_qb, d_imm, d_pc4;
  logic        e_wreg, e_m2reg, e_wmem, e_jal;
  logic [4:0]  e_rn;
  logic [31:0] e_qb, e_alua, e_alub, kill_cnt;
  logic [3:0]  e_aluc;

  logic        s_flush;
  logic        s_wreg, s_m2reg, s_wmem, s_jal;
  logic [4:0]  s_rn;
  logic [7:0]  s_qb, s_alua, s_alub, s_kill;
  logic [3:0]  s_aluc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_idex_reg #(.WIDTH(32), .RWIDTH(5)) dut (
    .clock(clock), .resetn(resetn), .en(en), .bubble(bubble), .flush(flush),
    .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem), .d_jal(d_jal),
    .d_aluimm(d_aluimm), .d_shift(d_shift), .d_aluc(d_aluc), .d_rn(d_rn),
    .d_sa(d_sa), .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .d_pc4(d_pc4),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_jal(e_jal),
    .e_rn(e_rn), .e_qb(e_qb), .e_alua(e_alua), .e_alub(e_alub),
    .e_aluc(e_aluc), .kill_cnt(kill_cnt)
  );

  // Narrow instance so the kill counter can be driven into saturation quickly.
  pipe_idex_reg #(.WIDTH(8), .RWIDTH(5)) dutSat (
    .clock(clock), .resetn(resetn), .en(1'b1), .bubble(1'b0), .flush(s_flush),
    .d_wreg(1'b1), .d_m2reg(1'b0), .d_wmem(1'b0), .d_jal(1'b0),
    .d_aluimm(1'b0), .d_shift(1'b0), .d_aluc(4'b0101), .d_rn(5'd6),
    .d_sa(5'd0), .d_qa(8'h11), .d_qb(8'h22), .d_imm(8'h33), .d_pc4(8'h44),
    .e_wreg(s_wreg), .e_m2reg(s_m2reg), .e_wmem(s_wmem), .e_jal(s_jal),
    .e_rn(s_rn), .e_qb(s_qb), .e_alua(s_alua), .e_alub(s_alub),
    .e_aluc(s_aluc), .kill_cnt(s_kill)
  );

  typedef struct {
    logic        en, bubble, flush, wreg, m2reg, wmem, jal, aluimm, shift;
    logic [3:0]  aluc;
    logic [4:0]  rn, sa;
    logic [31:0] qa, qb, imm, pc4;
    logic        xwreg, xm2reg, xwmem, xjal;
    logic [4:0]  xrn;
    logic [31:0] xqb, xalua, xalub;
    logic [3:0]  xaluc;
    logic [31:0] xkill;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic cmpVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    en       = v.en;
    bubble   = v.bubble;
    flush    = v.flush;
    d_wreg   = v.wreg;
    d_m2reg  = v.m2reg;
    d_wmem   = v.wmem;
    d_jal    = v.jal;
    d_aluimm = v.aluimm;
    d_shift  = v.shift;
    d_aluc   = v.aluc;
    d_rn     = v.rn;
    d_sa     = v.sa;
    d_qa     = v.qa;
    d_qb     = v.qb;
    d_imm    = v.imm;
    d_pc4    = v.pc4;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    cmpVal({tag, " e_wreg"},   32'(e_wreg),  32'(v.xwreg));
    cmpVal({tag, " e_m2reg"},  32'(e_m2reg), 32'(v.xm2reg));
    cmpVal({tag, " e_wmem"},   32'(e_wmem),  32'(v.xwmem));
    cmpVal({tag, " e_jal"},    32'(e_jal),   32'(v.xjal));
    cmpVal({tag, " e_rn"},     32'(e_rn),    32'(v.xrn));
    cmpVal({tag, " e_qb"},     e_qb,         v.xqb);
    cmpVal({tag, " e_alua"},   e_alua,       v.xalua);
    cmpVal({tag, " e_alub"},   e_alub,       v.xalub);
    cmpVal({tag, " e_aluc"},   32'(e_aluc),  32'(v.xaluc));
    cmpVal({tag, " kill_cnt"}, kill_cnt,     v.xkill);
  endtask

  initial begin
    vec_t zeroExp;
    zeroExp = '{default: '0};

    vecs[0]  = '{en:1'b1, wreg:1'b1, qa:32'd5, qb:32'd7, rn:5'd3,
                 xwreg:1'b1, xrn:5'd3, xqb:32'd7, xalua:32'd5, xalub:32'd7, default:'0};
    vecs[1]  = '{en:1'b1, wreg:1'b1, shift:1'b1, sa:5'd4, qb:32'h10, qa:32'h99, aluc:4'b0011, rn:5'd8,
                 xwreg:1'b1, xrn:5'd8, xqb:32'h10, xalua:32'd4, xalub:32'h10, xaluc:4'b0011, default:'0};
    vecs[2]  = '{en:1'b1, wreg:1'b1, aluimm:1'b1, imm:32'hFFFF, qb:32'h10, qa:32'h22, rn:5'd8,
                 xwreg:1'b1, xrn:5'd8, xqb:32'h10, xalua:32'h22, xalub:32'hFFFF, default:'0};
    vecs[3]  = '{en:1'b1, wreg:1'b1, jal:1'b1, pc4:32'h100, aluc:4'b0011, rn:5'd5, qa:32'd1, qb:32'd2,
                 xwreg:1'b1, xjal:1'b1, xrn:5'd31, xqb:32'd2, xalua:32'h100, xalub:32'd4, default:'0};
    vecs[4]  = '{en:1'b1, wreg:1'b1, m2reg:1'b1, rn:5'd9, qa:32'h1000, imm:32'd8, aluimm:1'b1, qb:32'd3,
                 xwreg:1'b1, xm2reg:1'b1, xrn:5'd9, xqb:32'd3, xalua:32'h1000, xalub:32'd8, default:'0};
    vecs[5]  = '{en:1'b1, bubble:1'b1, wreg:1'b1, wmem:1'b1, qa:32'hAA, qb:32'hBB, rn:5'd4, aluc:4'b0101,
                 xrn:5'd4, xqb:32'hBB, xalua:32'hAA, xalub:32'hBB, xaluc:4'b0101, xkill:32'd1, default:'0};
    vecs[6]  = '{en:1'b1, wmem:1'b1, qa:32'h40, imm:32'h10, aluimm:1'b1, qb:32'h1234,
                 xwmem:1'b1, xqb:32'h1234, xalua:32'h40, xalub:32'h10, xkill:32'd1, default:'0};
    vecs[7]  = '{en:1'b0, wreg:1'b1, jal:1'b1, qa:32'hDEAD, qb:32'hBEEF, rn:5'd12, aluc:4'b1111,
                 xwmem:1'b1, xqb:32'h1234, xalua:32'h40, xalub:32'h10, xkill:32'd1, default:'0};
    vecs[8]  = '{en:1'b0, bubble:1'b1, m2reg:1'b1, qa:32'h5A5A, imm:32'h77,
                 xwmem:1'b1, xqb:32'h1234, xalua:32'h40, xalub:32'h10, xkill:32'd1, default:'0};
    vecs[9]  = '{en:1'b0, flush:1'b1, wreg:1'b1, qa:32'h77, qb:32'h66, rn:5'd2,
                 xkill:32'd2, default:'0};
    vecs[10] = '{en:1'b1, bubble:1'b1, flush:1'b1, wreg:1'b1, qa:32'h55, rn:5'd3,
                 xkill:32'd3, default:'0};
    vecs[11] = '{en:1'b1, wreg:1'b1, shift:1'b1, sa:5'd31, aluimm:1'b1, imm:32'hFFFFFFF0,
                 aluc:4'b0111, rn:5'd7, qa:32'd1, qb:32'd2,
                 xwreg:1'b1, xrn:5'd7, xqb:32'd2, xalua:32'd31, xalub:32'hFFFFFFF0,
                 xaluc:4'b0111, xkill:32'd3, default:'0};
    vecs[12] = '{en:1'b1, wreg:1'b1, jal:1'b1, shift:1'b1, aluimm:1'b1, sa:5'd3, imm:32'h50,
                 pc4:32'h200, aluc:4'b0100, rn:5'd2, qa:32'h9, qb:32'hC,
                 xwreg:1'b1, xjal:1'b1, xrn:5'd31, xqb:32'hC, xalua:32'h200, xalub:32'd4,
                 xkill:32'd3, default:'0};

    s_flush = 1'b0;

    // Reset held across edges with random ID inputs.
    resetn = 1'b0;
    en = 1'b1; bubble = 1'b0; flush = 1'b0;
    d_wreg = 1'b1; d_m2reg = 1'b1; d_wmem = 1'b1; d_jal = 1'b0;
    d_aluimm = 1'b1; d_shift = 1'b1; d_aluc = 4'($urandom);
    d_rn = 5'($urandom); d_sa = 5'($urandom);
    d_qa = $urandom; d_qb = $urandom; d_imm = $urandom; d_pc4 = $urandom;
    repeat (2) @(posedge clock);
    #1;
    checkOutput(zeroExp, "reset");
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-cycle clears everything before the next edge.
    #2;
    resetn = 1'b0;
    #1;
    checkOutput(zeroExp, "asyncReset");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    applyStimulus(vecs[0]);
    checkOutput(vecs[0], "afterReset");

    // Drive the 8-bit kill counter to 0xFE, then past saturation.
    s_flush = 1'b1;
    repeat (254) @(posedge clock);
    #1;
    cmpVal("sat kill at 0xFE", 32'(s_kill), 32'hFE);
    cmpVal("sat flushed e_wreg", 32'(s_wreg), 32'd0);
    @(posedge clock);
    #1;
    cmpVal("sat kill at 0xFF", 32'(s_kill), 32'hFF);
    repeat (3) @(posedge clock);
    #1;
    cmpVal("sat kill stays 0xFF", 32'(s_kill), 32'hFF);
    s_flush = 1'b0;
    @(posedge clock);
    #1;
    cmpVal("sat kill after load", 32'(s_kill), 32'hFF);
    cmpVal("sat load e_alua", 32'(s_alua), 32'h11);
    cmpVal("sat load e_rn", 32'(s_rn), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
